// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. a FIFO of
// out-of-band long-latency results, with starvation/full stall of the pipeline.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DW       = 32,
  parameter int AW       = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [AW-1:0]            pipe_rd,
  input  logic [DW-1:0]            pipe_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [AW-1:0]            lu_rd,
  input  logic [DW-1:0]            lu_data,
  output logic                     stall_pipe,
  output logic                     reg_write,
  output logic [AW-1:0]            rd,
  output logic [DW-1:0]            result,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0] mem_rd_r   [DEPTH];
  logic [DW-1:0] mem_data_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [WW-1:0] wait_r;

  logic pipe_req_s;
  logic full_s;
  logic push_s;
  logic pop_s;
  logic grant_pipe_s;

  // Request qualification, handshake and grant priority.
  always_comb begin
    pipe_req_s   = pipe_we && (pipe_rd != {AW{1'b0}});
    full_s       = (count_r == CW'(DEPTH));
    lu_ready     = !full_s;
    push_s       = lu_valid && !full_s && (lu_rd != {AW{1'b0}});
    stall_pipe   = (count_r != {CW{1'b0}}) && ((wait_r >= WW'(MAX_WAIT)) || full_s);
    pop_s        = 1'b0;
    grant_pipe_s = 1'b0;
    if (stall_pipe) begin
      pop_s = 1'b1;
    end else if (pipe_req_s) begin
      grant_pipe_s = 1'b1;
    end else if (count_r != {CW{1'b0}}) begin
      pop_s = 1'b1;
    end else begin
      pop_s        = 1'b0;
      grant_pipe_s = 1'b0;
    end
  end

  assign fifo_count = count_r;

  // FIFO storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_rd_r[tail_r]   <= lu_rd;
      mem_data_r[tail_r] <= lu_data;
    end
  end

  // Pointers, occupancy and head wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      wait_r  <= {WW{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PW'(1);
      if (pop_s)  head_r <= head_r + PW'(1);
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
      // A fresh head (after a pop, or into an empty FIFO) starts waiting at 0.
      if ((count_r == {CW{1'b0}}) || pop_s) begin
        wait_r <= {WW{1'b0}};
      end else if (wait_r < WW'(MAX_WAIT)) begin
        wait_r <= wait_r + WW'(1);
      end else begin
        wait_r <= wait_r;
      end
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write <= 1'b0;
      rd        <= {AW{1'b0}};
      result    <= {DW{1'b0}};
    end else if (pop_s) begin
      reg_write <= 1'b1;
      rd        <= mem_rd_r[head_r];
      result    <= mem_data_r[head_r];
    end else if (grant_pipe_s) begin
      reg_write <= 1'b1;
      rd        <= pipe_rd;
      result    <= pipe_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule
